// File: rtl/isp_pkg.sv
// ============================================================================
// Module      : isp_pkg
// Description : Shared types, geometry defaults and the Bayer phase helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isp_pkg;

  localparam int ISP_WIDTH   = 320;
  localparam int ISP_HEIGHT  = 240;
  localparam int ISP_HBLANK  = 16;
  localparam int ISP_SOF_GAP = 32;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SOF         = 3'd1,
    ST_GAP         = 3'd2,
    ST_ACTIVE      = 3'd3,
    ST_HBLANK      = 3'd4,
    ST_FLUSH       = 3'd5,
    ST_FLUSH_BLANK = 3'd6,
    ST_DONE        = 3'd7
  } bayer_gen_state_t;

  typedef enum logic [1:0] {
    PH_G = 2'd0,
    PH_B = 2'd1,
    PH_R = 2'd2
  } bayer_phase_t;

  // GBGB on even rows, RGRG on odd rows.
  function automatic bayer_phase_t bayer_phase(input logic row_lsb, input logic col_lsb);
    if (!row_lsb) return col_lsb ? PH_B : PH_G;
    return col_lsb ? PH_G : PH_R;
  endfunction

  function automatic int isp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bayer_mosaic_sel.sv
// ============================================================================
// Module      : bayer_mosaic_sel
// Description : Picks the one colour sample a Bayer site keeps from an RGB pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bayer_mosaic_sel
  import isp_pkg::*;
(
  input  logic       i_row_lsb,
  input  logic       i_col_lsb,
  input  logic [7:0] i_r,
  input  logic [7:0] i_g,
  input  logic [7:0] i_b,
  output logic [7:0] o_sample
);

  bayer_phase_t w_phase;

  assign w_phase = bayer_phase(i_row_lsb, i_col_lsb);

  always_comb begin
    o_sample = i_g;
    case (w_phase)
      PH_R:    o_sample = i_r;
      PH_B:    o_sample = i_b;
      default: o_sample = i_g;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bayer_stream_gen.sv
// ============================================================================
// Module      : bayer_stream_gen
// Description : RGB-in, framed raw Bayer stream out (newFrame, gap, hblank).
//               Define BAYER_FLUSH_EN to append zero rows until downstream done.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bayer_stream_gen #(
  parameter int width  = isp_pkg::ISP_WIDTH,
  parameter int height = isp_pkg::ISP_HEIGHT,
  parameter int hblank = isp_pkg::ISP_HBLANK,
  parameter int sofGap = isp_pkg::ISP_SOF_GAP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iStart,
  input  logic [7:0] iR,
  input  logic [7:0] iG,
  input  logic [7:0] iB,
  input  logic       iValid,
  output logic       oReady,
  input  logic       iDownstreamDone,
  output logic       newFrame,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic       oFrameDone
);

  import isp_pkg::*;

  localparam int c_COL_W = (width  > 1) ? $clog2(width)  : 1;
  localparam int c_ROW_W = (height > 1) ? $clog2(height) : 1;
  localparam int c_CNT_W = isp_max($clog2(isp_max(hblank, sofGap) + 1), 1);

  localparam logic [c_COL_W-1:0] c_COL_LAST    = c_COL_W'(width - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST    = c_ROW_W'(height - 1);
  localparam logic [c_CNT_W-1:0] c_HBLANK_LAST = c_CNT_W'(hblank - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST    = c_CNT_W'(sofGap - 1);

  bayer_gen_state_t   r_state;
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_new_frame;
  logic               r_valid;
  logic [7:0]         r_data;
  logic               r_frame_done;
  logic [7:0]         w_sample;
  logic               w_handshake;

`ifdef BAYER_FLUSH_EN
  logic r_ds_seen;
`else
  logic w_unused_ds;
  assign w_unused_ds = iDownstreamDone;
`endif

  bayer_mosaic_sel u_mosaic (
    .i_row_lsb (r_row[0]),
    .i_col_lsb (r_col[0]),
    .i_r       (iR),
    .i_g       (iG),
    .i_b       (iB),
    .o_sample  (w_sample)
  );

  assign oReady      = (r_state == ST_ACTIVE);
  assign w_handshake = oReady && iValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_cnt        <= '0;
      r_new_frame  <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
`ifdef BAYER_FLUSH_EN
      r_ds_seen    <= 1'b0;
`endif
    end else begin
      r_new_frame  <= 1'b0;
      r_frame_done <= 1'b0;
      r_valid      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (iStart) begin
            r_state     <= ST_SOF;
            r_new_frame <= 1'b1;
          end
        end
        ST_SOF: begin
          r_cnt   <= '0;
          r_state <= ST_GAP;
        end
        ST_GAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_ACTIVE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ACTIVE: begin
          // Stalls leave col/row untouched, so the mosaic phase survives them.
          if (w_handshake) begin
            r_valid <= 1'b1;
            r_data  <= w_sample;
            if (r_col == c_COL_LAST) begin
              r_col   <= '0;
              r_cnt   <= '0;
              r_state <= ST_HBLANK;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_HBLANK: begin
          if (r_cnt == c_HBLANK_LAST) begin
            r_cnt <= '0;
            if (r_row != c_ROW_LAST) begin
              r_row   <= r_row + 1'b1;
              r_state <= ST_ACTIVE;
            end else begin
              r_row <= '0;
`ifdef BAYER_FLUSH_EN
              r_ds_seen <= 1'b0;
              r_state   <= ST_FLUSH;
`else
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
`endif
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef BAYER_FLUSH_EN
        ST_FLUSH: begin
          r_valid <= 1'b1;
          r_data  <= '0;
          if (iDownstreamDone) r_ds_seen <= 1'b1;
          if (r_col == c_COL_LAST) begin
            r_col   <= '0;
            r_cnt   <= '0;
            r_state <= ST_FLUSH_BLANK;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        ST_FLUSH_BLANK: begin
          if (iDownstreamDone) r_ds_seen <= 1'b1;
          if (r_cnt == c_HBLANK_LAST) begin
            r_cnt <= '0;
            if (r_ds_seen || iDownstreamDone) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_state <= ST_FLUSH;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign newFrame   = r_new_frame;
  assign oValid     = r_valid;
  assign oData      = r_data;
  assign oFrameDone = r_frame_done;
  assign oBusy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bayer_stream_gen.sv
// ============================================================================
// Module      : tb_bayer_stream_gen
// Description : Self-checking bench for bayer_stream_gen on a 4x2 frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bayer_stream_gen;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int HB   = 16;
  localparam int SG   = 32;
  localparam int NPIX = W * H;
`ifdef BAYER_FLUSH_EN
  localparam int EXP_N = NPIX + 2 * W;
`else
  localparam int EXP_N = NPIX;
`endif

  localparam int STALL_NONE   = 0;
  localparam int STALL_MID    = 1;
  localparam int STALL_RAND   = 2;
  localparam int START_ACTIVE = 3;
  localparam int RESET_MID    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       iStart;
  logic [7:0] iR, iG, iB;
  logic       iValid;
  logic       oReady;
  logic       iDownstreamDone;
  logic       newFrame;
  logic       oValid;
  logic [7:0] oData;
  logic       oBusy;
  logic       oFrameDone;

  always #5 clk = ~clk;

  bayer_stream_gen #(
    .width  (W),
    .height (H),
    .hblank (HB),
    .sofGap (SG)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .iStart          (iStart),
    .iR              (iR),
    .iG              (iG),
    .iB              (iB),
    .iValid          (iValid),
    .oReady          (oReady),
    .iDownstreamDone (iDownstreamDone),
    .newFrame        (newFrame),
    .oValid          (oValid),
    .oData           (oData),
    .oBusy           (oBusy),
    .oFrameDone      (oFrameDone)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  px_r [NPIX];
  logic [7:0]  px_g [NPIX];
  logic [7:0]  px_b [NPIX];
  logic [7:0]  got_data [$];
  int          got_time [$];
  int          nf_time [$];
  int          done_time [$];
  int          first_ready;
  int          busy_err;
  logic [12:0] rst_snap;

  // Reference: pixel p sits at row p/W, col p%W; flush samples are zero.
  function automatic logic [7:0] ref_sample(input int p);
    int row, col;
    if (p >= NPIX) return 8'h00;
    row = p / W;
    col = p % W;
    if (row % 2 == 0) return (col % 2 == 0) ? px_g[p] : px_b[p];
    return (col % 2 == 0) ? px_r[p] : px_g[p];
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'($urandom);
      px_g[i] = 8'($urandom);
      px_b[i] = 8'($urandom);
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < NPIX; i++) begin
      px_r[i] = 8'(i);
      px_g[i] = 8'(8'h40 + i);
      px_b[i] = 8'(8'h80 + i);
    end
  endtask

  // Drives one frame and records what the DUT emits; k counts cycles after iStart is sampled.
  task automatic run_frame(input int mode);
    int p, k, stalled, rst_k;
    p = 0; k = 0; stalled = 0; rst_k = -1;
    got_data.delete(); got_time.delete(); nf_time.delete(); done_time.delete();
    first_ready = -1; busy_err = 0; rst_snap = '1;
    @(negedge clk);
    iStart = 1'b1;
    iValid = 1'b1;
    {iR, iG, iB} = {px_r[0], px_g[0], px_b[0]};
    while (k < 3000) begin
      @(negedge clk);
      k++;
      if (newFrame) nf_time.push_back(k);
      if (oValid) begin
        got_data.push_back(oData);
        got_time.push_back(k);
      end
      if (oFrameDone) done_time.push_back(k);
      if (oReady && first_ready < 0) first_ready = k;
      if (mode != RESET_MID && oBusy !== (done_time.size() == 0 || k == done_time[0])) busy_err++;
      if (rst_k >= 0 && k == rst_k + 1)
        rst_snap = {newFrame, oValid, oData, oBusy, oFrameDone, oReady};
      if (done_time.size() > 0 && k >= done_time[0] + 4) break;
      if (rst_k >= 0 && k >= rst_k + 40) break;
      iStart = (mode == START_ACTIVE) && oReady;
      reset  = 1'b0;
      case (mode)
        STALL_MID: begin
          if (oReady && p == 2 && stalled < 3) begin
            iValid = 1'b0;
            stalled++;
          end else begin
            iValid = 1'b1;
          end
        end
        STALL_RAND: iValid = ($urandom_range(3) != 0);
        default:    iValid = 1'b1;
      endcase
      if (mode == RESET_MID && rst_k < 0 && p == W + 2) begin
        reset  = 1'b1;
        iValid = 1'b0;
        rst_k  = k;
      end
      iDownstreamDone = (got_data.size() == NPIX + W + 2);
      if (p < NPIX) {iR, iG, iB} = {px_r[p], px_g[p], px_b[p]};
      else          {iR, iG, iB} = 24'($urandom);
      if (oReady && iValid) p++;
    end
    iStart = 1'b0; iValid = 1'b0; iDownstreamDone = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iStart = 1'b0; iValid = 1'b0; iDownstreamDone = 1'b0;
    {iR, iG, iB} = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({newFrame, oValid, oData, oBusy, oFrameDone, oReady} !== 13'd0)
      $display("FAIL reset_outputs: got %h expected 0", {newFrame, oValid, oData, oBusy, oFrameDone, oReady});
    else n_pass++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({newFrame, oValid, oBusy, oFrameDone, oReady} !== 5'd0)
      $display("FAIL idle_hold: got %b expected 0", {newFrame, oValid, oBusy, oFrameDone, oReady});
    else n_pass++;
  endtask

  task automatic test_mosaic();
    logic [7:0] mos_exp [8];
    mos_exp = '{8'h40, 8'h81, 8'h42, 8'h83, 8'h04, 8'h45, 8'h06, 8'h47};
    fill_pattern();
    run_frame(STALL_NONE);
    n_checks++;
    if (got_data.size() !== EXP_N) $display("FAIL mosaic_count: got %0d expected %0d", got_data.size(), EXP_N);
    else n_pass++;
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== mos_exp[i]) $display("FAIL mosaic_sample[%0d]: got %h expected %h", i, got_data[i], mos_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    fill_random();
    run_frame(STALL_NONE);
    n_checks++;
    if (nf_time.size() !== 1 || nf_time[0] !== 1)
      $display("FAIL newframe: got count %0d at %0d expected 1 at 1", nf_time.size(), nf_time[0]);
    else n_pass++;
    n_checks++;
    if (first_ready !== 2 + SG) $display("FAIL ready_rise: got %0d expected %0d", first_ready, 2 + SG);
    else n_pass++;
    n_checks++;
    if (got_time[W] - got_time[W-1] - 1 !== HB)
      $display("FAIL row_gap: got %0d expected %0d", got_time[W] - got_time[W-1] - 1, HB);
    else n_pass++;
    n_checks++;
    if (got_time[W] - got_time[0] !== W + HB)
      $display("FAIL row_pitch: got %0d expected %0d", got_time[W] - got_time[0], W + HB);
    else n_pass++;
    n_checks++;
    if (done_time.size() !== 1) $display("FAIL done_count: got %0d expected 1", done_time.size());
    else n_pass++;
    n_checks++;
    if (done_time[0] !== got_time[got_time.size()-1] + HB)
      $display("FAIL done_time: got %0d expected %0d", done_time[0], got_time[got_time.size()-1] + HB);
    else n_pass++;
    n_checks++;
    if (busy_err !== 0) $display("FAIL busy: got %0d bad cycles expected 0", busy_err);
    else n_pass++;
    n_checks++;
    if (got_data.size() !== EXP_N) $display("FAIL frame_count: got %0d expected %0d", got_data.size(), EXP_N);
    else n_pass++;
    for (int i = 0; i < EXP_N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== ref_sample(i)) $display("FAIL frame_sample[%0d]: got %h expected %h", i, got_data[i], ref_sample(i));
      else n_pass++;
    end
`ifdef BAYER_FLUSH_EN
    n_checks++;
    if (got_time[NPIX] - got_time[NPIX-1] - 1 !== HB)
      $display("FAIL flush_entry_gap: got %0d expected %0d", got_time[NPIX] - got_time[NPIX-1] - 1, HB);
    else n_pass++;
    n_checks++;
    if (got_time[NPIX+W] - got_time[NPIX+W-1] - 1 !== HB)
      $display("FAIL flush_row_gap: got %0d expected %0d", got_time[NPIX+W] - got_time[NPIX+W-1] - 1, HB);
    else n_pass++;
`endif
  endtask

  task automatic test_stalls();
    fill_random();
    run_frame(STALL_MID);
    n_checks++;
    if (got_time[W-1] - got_time[0] - (W - 1) !== 3)
      $display("FAIL stall_gaps: got %0d expected 3", got_time[W-1] - got_time[0] - (W - 1));
    else n_pass++;
    for (int i = 0; i < EXP_N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== ref_sample(i)) $display("FAIL stall_sample[%0d]: got %h expected %h", i, got_data[i], ref_sample(i));
      else n_pass++;
    end
    for (int f = 0; f < 3; f++) begin
      fill_random();
      run_frame(STALL_RAND);
      n_checks++;
      if (got_data.size() !== EXP_N) $display("FAIL rand_count: got %0d expected %0d", got_data.size(), EXP_N);
      else n_pass++;
      for (int i = 0; i < EXP_N && i < got_data.size(); i++) begin
        n_checks++;
        if (got_data[i] !== ref_sample(i)) $display("FAIL rand_sample[%0d]: got %h expected %h", i, got_data[i], ref_sample(i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_ignored_inputs();
    fill_random();
    run_frame(START_ACTIVE);
    n_checks++;
    if (nf_time.size() !== 1) $display("FAIL restart_ignored: got %0d newFrame expected 1", nf_time.size());
    else n_pass++;
    n_checks++;
    if (got_data[0] !== px_g[0]) $display("FAIL held_first_pixel: got %h expected %h", got_data[0], px_g[0]);
    else n_pass++;
    n_checks++;
    if (got_data[W] !== px_r[W]) $display("FAIL held_row1_pixel: got %h expected %h", got_data[W], px_r[W]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    fill_random();
    run_frame(RESET_MID);
    n_checks++;
    if (rst_snap !== 13'd0) $display("FAIL reset_mid_outputs: got %h expected 0", rst_snap);
    else n_pass++;
    n_checks++;
    if (done_time.size() !== 0) $display("FAIL reset_mid_done: got %0d pulses expected 0", done_time.size());
    else n_pass++;
    fill_random();
    run_frame(STALL_NONE);
    n_checks++;
    if (got_data.size() !== EXP_N) $display("FAIL restart_count: got %0d expected %0d", got_data.size(), EXP_N);
    else n_pass++;
    for (int i = 0; i < EXP_N && i < got_data.size(); i++) begin
      n_checks++;
      if (got_data[i] !== ref_sample(i)) $display("FAIL restart_sample[%0d]: got %h expected %h", i, got_data[i], ref_sample(i));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mosaic();
    test_framing();
    test_stalls();
    test_ignored_inputs();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
